// File: rtl/pay_pkg.sv
// Shared types and helpers for the pay_ctrl_n payment-menu controller.
package pay_pkg;

    typedef enum logic [2:0] {
        StMenu,
        StCash,
        StAuth,
        StChange,
        StReceipt,
        StFinish,
        StDisabled
    } pay_state_t;

    localparam int unsigned CASH_IDX = 0;

    // Adds two amounts and clamps to the all-ones value of a width-bit bus.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << width) - 33'd1;
        return 32'((sum > max) ? max : sum);
    endfunction

endpackage

// File: rtl/pay_timeout_cnt.sv
// Idle-cycle counter with synchronous clear, count enable and a terminal flag.
module pay_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pay_ctrl_n.sv
// Payment-menu controller: cash/electronic selection, change, refund, receipt, finish.
// Define PAY_MENU_WRAP_EN to make menu navigation wrap instead of saturate.
module pay_ctrl_n
    import pay_pkg::*;
#(
    parameter int unsigned N_METHODS   = 2,
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned RECEIPT_CYC = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    input  logic                         btn_sel,
    input  logic                         btn_cancel,
    input  logic [AMT_W-1:0]             price,
    input  logic                         coin_valid,
    input  logic [AMT_W-1:0]             coin_val,
    input  logic                         auth_ok,
    input  logic                         auth_fail,
    output logic [$clog2(N_METHODS)-1:0] method_idx,
    output logic                         auth_req,
    output logic                         change_valid,
    output logic [AMT_W-1:0]             change_amt,
    output logic                         receipt,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned IW = $clog2(N_METHODS);
    localparam int unsigned RW = $clog2(RECEIPT_CYC + 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_METHODS - 1);
    localparam logic [RW-1:0] RCPT_LAST = RW'(RECEIPT_CYC - 1);

    pay_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AMT_W-1:0] credit_q, credit_d, price_q, price_d, credit_plus;
    logic [RW-1:0] rcpt_q, rcpt_d;
    logic change_valid_d, err_d;
    logic [AMT_W-1:0] change_amt_d;
    logic activity, in_wait, to_expired, timeout;

    assign activity = coin_valid | btn_next | btn_prev | btn_sel | btn_cancel;
    assign in_wait  = (state_q == StCash) || (state_q == StAuth);
    // A coin or button arriving on the terminal cycle restarts the idle window.
    assign timeout  = to_expired && !activity;
    assign credit_plus = AMT_W'(sat_add(32'(credit_q), coin_valid ? 32'(coin_val) : 32'd0,
                                        AMT_W));

    pay_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (!in_wait || activity),
        .en     (in_wait),
        .expired(to_expired)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        credit_d       = credit_q;
        price_d        = price_q;
        rcpt_d         = '0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        err_d          = 1'b0;
        if (!en) begin
            if (state_q != StDisabled) begin
                state_d        = StDisabled;
                change_valid_d = (credit_q != '0);
                change_amt_d   = credit_q;
                credit_d       = '0;
            end
        end else begin
            unique case (state_q)
                StMenu: begin
`ifdef PAY_MENU_WRAP_EN
                    if (btn_next) begin
                        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
                    end else if (btn_prev) begin
                        idx_d = (idx_q == '0) ? IDX_MAX : idx_q - 1'b1;
                    end else
`else
                    if (btn_next) begin
                        idx_d = (idx_q == IDX_MAX) ? idx_q : idx_q + 1'b1;
                    end else if (btn_prev) begin
                        idx_d = (idx_q == '0) ? idx_q : idx_q - 1'b1;
                    end else
`endif
                    if (btn_sel) begin
                        price_d  = price;
                        credit_d = '0;
                        state_d  = (idx_q == IW'(CASH_IDX)) ? StCash : StAuth;
                    end
                end
                StCash: begin
                    if (btn_cancel) begin
                        change_valid_d = (credit_plus != '0);
                        change_amt_d   = credit_plus;
                        credit_d       = '0;
                        state_d        = StMenu;
                    end else if (credit_q >= price_q) begin
                        credit_d = credit_plus;
                        state_d  = StChange;
                    end else if (timeout) begin
                        err_d          = 1'b1;
                        change_valid_d = (credit_q != '0);
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                        state_d        = StMenu;
                    end else begin
                        credit_d = credit_plus;
                    end
                end
                StAuth: begin
                    if (auth_fail || btn_cancel) begin
                        err_d   = auth_fail;
                        state_d = StMenu;
                    end else if (auth_ok) begin
                        state_d = StReceipt;
                    end else if (timeout) begin
                        err_d   = 1'b1;
                        state_d = StMenu;
                    end
                end
                StChange: begin
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q - price_q;
                    credit_d       = '0;
                    state_d        = StReceipt;
                end
                StReceipt: begin
                    if (rcpt_q == RCPT_LAST) begin
                        state_d = StFinish;
                    end else begin
                        rcpt_d = rcpt_q + 1'b1;
                    end
                end
                StFinish: begin
                    if (btn_sel || btn_cancel) begin
                        state_d = StMenu;
                    end
                end
                StDisabled: begin
                    idx_d   = '0;
                    state_d = StMenu;
                end
                default: state_d = StMenu;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StMenu;
            idx_q        <= '0;
            credit_q     <= '0;
            price_q      <= '0;
            rcpt_q       <= '0;
            auth_req     <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            receipt      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            credit_q     <= credit_d;
            price_q      <= price_d;
            rcpt_q       <= rcpt_d;
            auth_req     <= (state_d == StAuth);
            change_valid <= change_valid_d;
            change_amt   <= change_amt_d;
            receipt      <= (state_d == StReceipt);
            done         <= (state_d == StFinish);
            err          <= err_d;
        end
    end

    assign method_idx = idx_q;

endmodule

// File: tb/tb_pay_ctrl_n.sv
// Randomised self-checking bench for pay_ctrl_n against a transaction-level model.
module tb_pay_ctrl_n;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int RC = 4;

    logic clk = 1'b0;
    logic reset, en, btn_next, btn_prev, btn_sel, btn_cancel, coin_valid, auth_ok, auth_fail;
    logic [W-1:0] price, coin_val, change_amt;
    logic [1:0] method_idx;
    logic auth_req, change_valid, receipt, done, err;

    int total = 0;
    int bad = 0;
    int m_idx = 0;
    int m_credit = 0;
    int chg_q[$];
    int err_n = 0;
    int rcpt_n = 0;

    pay_ctrl_n #(
        .N_METHODS  (N),
        .AMT_W      (W),
        .TIMEOUT_CYC(TO),
        .RECEIPT_CYC(RC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .btn_sel     (btn_sel),
        .btn_cancel  (btn_cancel),
        .price       (price),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .auth_ok     (auth_ok),
        .auth_fail   (auth_fail),
        .method_idx  (method_idx),
        .auth_req    (auth_req),
        .change_valid(change_valid),
        .change_amt  (change_amt),
        .receipt     (receipt),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Pulse observer: collects refunds/change, error pulses and receipt-high cycles.
    always @(negedge clk) begin
        if (!reset) begin
            if (change_valid) chg_q.push_back(int'(change_amt));
            if (err) err_n++;
            if (receipt) rcpt_n++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        chg_q.delete();
        err_n = 0;
        rcpt_n = 0;
    endtask

    task automatic press(input int b);
        case (b)
            0: btn_next = 1'b1;
            1: btn_prev = 1'b1;
            2: btn_sel = 1'b1;
            default: btn_cancel = 1'b1;
        endcase
        step(1);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_sel = 1'b0;
        btn_cancel = 1'b0;
    endtask

    function automatic int nav_model(input int idx, input bit fwd);
`ifdef PAY_MENU_WRAP_EN
        return fwd ? (idx + 1) % N : (idx + N - 1) % N;
`else
        return fwd ? ((idx < N - 1) ? idx + 1 : idx) : ((idx > 0) ? idx - 1 : 0);
`endif
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic go_idx(input int t);
        while (m_idx != t) begin
            if (t > m_idx) begin
                press(0);
                m_idx = nav_model(m_idx, 1'b1);
            end else begin
                press(1);
                m_idx = nav_model(m_idx, 1'b0);
            end
        end
    endtask

    task automatic cash_start(input int p);
        go_idx(0);
        price = W'(p);
        press(2);
        m_credit = 0;
    endtask

    task automatic insert_coin(input int v);
        coin_valid = 1'b1;
        coin_val = W'(v);
        step(1);
        coin_valid = 1'b0;
        step(1);
        m_credit = sat(m_credit + v);
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        total++; if (method_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", method_idx); end
        total++; if ({auth_req, change_valid, receipt, done, err} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {auth_req, change_valid, receipt, done, err});
        end
        total++; if (change_amt !== 8'd0) begin bad++; $display("FAIL reset_amt: got %0d want 0", change_amt); end
    endtask

    task automatic test_nav();
        for (int i = 0; i < 4; i++) begin
            press(0);
            m_idx = nav_model(m_idx, 1'b1);
            total++; if (method_idx !== 2'(m_idx)) begin bad++; $display("FAIL nav_next: got %0d want %0d", method_idx, m_idx); end
        end
        go_idx(2);
        for (int i = 0; i < 4; i++) begin
            press(1);
            m_idx = nav_model(m_idx, 1'b0);
            total++; if (method_idx !== 2'(m_idx)) begin bad++; $display("FAIL nav_prev: got %0d want %0d", method_idx, m_idx); end
        end
        for (int i = 0; i < 10; i++) begin
            bit fwd = 1'($urandom_range(0, 1));
            press(fwd ? 0 : 1);
            m_idx = nav_model(m_idx, fwd);
            total++; if (method_idx !== 2'(m_idx)) begin bad++; $display("FAIL nav_rand: got %0d want %0d", method_idx, m_idx); end
        end
    endtask

    task automatic test_cash();
        bit ok;
        for (int t = 0; t < 6; t++) begin
            int p, k;
            p = (t == 0) ? 50 : (t == 1) ? 35 : $urandom_range(0, 150);
            k = 0;
            clear_mon();
            cash_start(p);
            while (m_credit < p) begin
                insert_coin((t == 0) ? ((k == 0) ? 20 : 30) : (t == 1) ? 25 : $urandom_range(1, 60));
                k++;
            end
            wait_done(30, ok);
            total++; if (!ok) begin bad++; $display("FAIL cash_done: done=%b want 1 (price %0d)", done, p); end
            total++; if (chg_q.size() != 1 || chg_q[0] != m_credit - p) begin
                bad++; $display("FAIL cash_change: got %p want [%0d]", chg_q, m_credit - p);
            end
            total++; if (rcpt_n != RC) begin bad++; $display("FAIL cash_receipt: got %0d cycles want %0d", rcpt_n, RC); end
            total++; if (err_n != 0) begin bad++; $display("FAIL cash_err: got %0d pulses want 0", err_n); end
            press(2);
            total++; if (done !== 1'b0 || method_idx !== 2'd0) begin
                bad++; $display("FAIL cash_ack: done=%b idx=%0d want 0/0", done, method_idx);
            end
        end
    endtask

    task automatic test_cancel();
        int exp;
        for (int t = 0; t < 2; t++) begin
            clear_mon();
            cash_start((t == 0) ? 200 : 255);
            if (t == 0) insert_coin(40);
            else begin
                insert_coin(200);
                insert_coin(50);
            end
            exp = sat(m_credit + ((t == 0) ? 10 : 20));
            coin_valid = 1'b1;
            coin_val = (t == 0) ? 8'd10 : 8'd20;
            btn_cancel = 1'b1;
            step(1);
            coin_valid = 1'b0;
            btn_cancel = 1'b0;
            step(6);
            total++; if (chg_q.size() != 1 || chg_q[0] != exp) begin
                bad++; $display("FAIL cancel_refund: got %p want [%0d]", chg_q, exp);
            end
            total++; if (rcpt_n != 0 || done !== 1'b0) begin
                bad++; $display("FAIL cancel_norcpt: receipt=%0d done=%b want 0/0", rcpt_n, done);
            end
            press(0);
            m_idx = nav_model(m_idx, 1'b1);
            total++; if (method_idx !== 2'(m_idx)) begin bad++; $display("FAIL cancel_menu: idx=%0d want %0d", method_idx, m_idx); end
        end
    endtask

    task automatic test_auth();
        bit ok;
        go_idx(1);
        clear_mon();
        press(2);
        total++; if (auth_req !== 1'b1) begin bad++; $display("FAIL auth_req: got %b want 1", auth_req); end
        auth_fail = 1'b1; step(1); auth_fail = 1'b0; step(2);
        total++; if (err_n != 1 || auth_req !== 1'b0) begin
            bad++; $display("FAIL auth_fail: err=%0d req=%b want 1/0", err_n, auth_req);
        end
        clear_mon();
        press(2);
        auth_ok = 1'b1; step(1); auth_ok = 1'b0;
        wait_done(20, ok);
        total++; if (!ok || rcpt_n != RC || err_n != 0) begin
            bad++; $display("FAIL auth_ok: done=%b receipt=%0d err=%0d want 1/%0d/0", done, rcpt_n, err_n, RC);
        end
        press(2);
        total++; if (method_idx !== 2'd1 || done !== 1'b0) begin
            bad++; $display("FAIL auth_retain: idx=%0d done=%b want 1/0", method_idx, done);
        end
        clear_mon();
        press(2);
        auth_ok = 1'b1; auth_fail = 1'b1; step(1); auth_ok = 1'b0; auth_fail = 1'b0; step(6);
        total++; if (err_n != 1 || rcpt_n != 0 || done !== 1'b0 || auth_req !== 1'b0) begin
            bad++; $display("FAIL auth_both: err=%0d receipt=%0d done=%b req=%b want 1/0/0/0", err_n, rcpt_n, done, auth_req);
        end
        clear_mon();
        press(2);
        press(3);
        step(2);
        total++; if (err_n != 0 || auth_req !== 1'b0) begin
            bad++; $display("FAIL auth_cancel: err=%0d req=%b want 0/0", err_n, auth_req);
        end
    endtask

    task automatic test_timeout();
        int n;
        clear_mon();
        cash_start(100);
        coin_valid = 1'b1; coin_val = 8'd10; step(1); coin_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            step(1);
            if (err === 1'b1) begin n = i; break; end
        end
        total++; if (n < TO || n > TO + 2) begin bad++; $display("FAIL timeout_cash: err after %0d idle cycles want %0d..%0d", n, TO, TO + 2); end
        step(2);
        total++; if (chg_q.size() != 1 || chg_q[0] != 10 || err_n != 1) begin
            bad++; $display("FAIL timeout_refund: got %p err=%0d want [10] err=1", chg_q, err_n);
        end
        clear_mon();
        go_idx(1);
        press(2);
        step(TO + 4);
        total++; if (err_n != 1 || auth_req !== 1'b0 || chg_q.size() != 0) begin
            bad++; $display("FAIL timeout_auth: err=%0d req=%b chg=%0d want 1/0/0", err_n, auth_req, chg_q.size());
        end
    endtask

    task automatic test_disable();
        clear_mon();
        cash_start(100);
        insert_coin(5);
        en = 1'b0;
        step(2);
        total++; if (chg_q.size() != 1 || chg_q[0] != 5) begin bad++; $display("FAIL dis_refund: got %p want [5]", chg_q); end
        press(2);
        press(0);
        step(2);
        total++; if (auth_req !== 1'b0 || done !== 1'b0 || chg_q.size() != 1) begin
            bad++; $display("FAIL dis_hold: req=%b done=%b chg=%0d want 0/0/1", auth_req, done, chg_q.size());
        end
        en = 1'b1;
        step(2);
        m_idx = 0;
        go_idx(2);
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(2);
        m_idx = 0;
        total++; if (method_idx !== 2'd0 || chg_q.size() != 1) begin
            bad++; $display("FAIL dis_resume: idx=%0d chg=%0d want 0/1", method_idx, chg_q.size());
        end
    endtask

    task automatic test_reset_receipt();
        bit seen;
        go_idx(1);
        press(2);
        auth_ok = 1'b1; step(1); auth_ok = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (receipt === 1'b1) begin seen = 1'b1; break; end
            step(1);
        end
        total++; if (!seen) begin bad++; $display("FAIL rr_receipt: receipt=%b want 1", receipt); end
        #2 reset = 1'b1;
        #1;
        total++; if ({auth_req, change_valid, receipt, done, err} !== 5'b0 || method_idx !== 2'd0) begin
            bad++; $display("FAIL rr_async: flags=%b idx=%0d want 00000/0", {auth_req, change_valid, receipt, done, err}, method_idx);
        end
        @(negedge clk);
        reset = 1'b0;
        m_idx = 0;
        step(1);
        press(0);
        m_idx = nav_model(m_idx, 1'b1);
        total++; if (method_idx !== 2'(m_idx) || receipt !== 1'b0) begin
            bad++; $display("FAIL rr_menu: idx=%0d receipt=%b want %0d/0", method_idx, receipt, m_idx);
        end
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_sel = 1'b0;
        btn_cancel = 1'b0;
        price = '0;
        coin_valid = 1'b0;
        coin_val = '0;
        auth_ok = 1'b0;
        auth_fail = 1'b0;
        step(2);
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1);
        test_reset();
        test_nav();
        test_cash();
        test_cancel();
        test_auth();
        test_timeout();
        test_disable();
        test_reset_receipt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
